// File: rtl/su_adder_ctrl.sv
// Sequencer for the su_adder psum reduction and the ping-pong psum GBF banks.
// Optional BANK_WAIT stall counter is built when SU_CTRL_PERF_CNT_EN is defined.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a layer config, cfg_ready high
// WAIT_PE   | PE array computing a tile, waiting for pe_done
// BANK_WAIT | tile done but its target GBF bank is still full, PE stalled
// ADD       | su_adder draining psum RF entries into cur_bank
// FLUSH     | last tile reduced, waiting for both banks to drain
// DONE      | one-cycle layer_done pulse
module su_adder_ctrl #(
  parameter int PSUM_RF_ADDR_BITWIDTH = 2,
  parameter int TILE_BITWIDTH         = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [4:0]                       cfg_irrel_num,
  input  logic [TILE_BITWIDTH-1:0]         cfg_tile_num,
  input  logic [PSUM_RF_ADDR_BITWIDTH:0]   cfg_rf_entries,
  input  logic                             pe_done,
  output logic                             pe_hold,
  output logic [4:0]                       irrel_num,
  output logic                             pe_psum_finish,
  input  logic                             su_add_finish,
  output logic                             conv_finish,
  output logic                             cur_bank,
  output logic                             drain_req,
  output logic                             drain_bank,
  input  logic                             drain_ack,
  output logic [TILE_BITWIDTH-1:0]         tile_cnt,
  output logic                             layer_done,
  output logic [15:0]                      stall_cycles
);

  localparam int RW = PSUM_RF_ADDR_BITWIDTH + 1;
  localparam logic [RW-1:0] RF_ONE = RW'(1);
  localparam logic [RW-1:0] RF_MAX = RW'(1) << PSUM_RF_ADDR_BITWIDTH;
  localparam logic [TILE_BITWIDTH-1:0] TILE_ONE = TILE_BITWIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PE,
    S_BANK_WAIT,
    S_ADD,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [TILE_BITWIDTH-1:0] tile_num_q;
  logic [RW-1:0]            rf_entries_q;
  logic [RW-1:0]            entry_cnt;
  logic [1:0]               bank_full, bank_full_nxt;
  logic                     drain_ptr;

  logic                     cfg_accept;
  logic                     add_step;
  logic                     tile_end;
  logic                     layer_end;
  logic                     drain_fire;
  logic [RW-1:0]            entry_inc;
  logic [TILE_BITWIDTH-1:0] tile_inc;
  logic [4:0]               irrel_coerced;
  logic [TILE_BITWIDTH-1:0] tile_coerced;
  logic [RW-1:0]            rf_coerced;

  assign cfg_accept = (state == S_IDLE) && cfg_valid;
  assign add_step   = (state == S_ADD) && su_add_finish;
  assign entry_inc  = entry_cnt + RF_ONE;
  assign tile_inc   = tile_cnt + TILE_ONE;
  assign tile_end   = add_step && (entry_inc == rf_entries_q);
  assign layer_end  = tile_end && (tile_inc == tile_num_q);

  assign drain_req  = |bank_full;
  assign drain_bank = drain_ptr;
  assign drain_fire = drain_ack && drain_req;

  // Degenerate configs are coerced to something the sequencer can finish.
  always_comb begin
    irrel_coerced = (cfg_irrel_num == 5'd0) ? 5'd1 : cfg_irrel_num;
    tile_coerced  = (cfg_tile_num == '0) ? TILE_ONE : cfg_tile_num;
    rf_coerced    = cfg_rf_entries;
    if (cfg_rf_entries == '0)
      rf_coerced = RF_ONE;
    else if (cfg_rf_entries > RF_MAX)
      rf_coerced = RF_MAX;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (cfg_valid) state_nxt = S_WAIT_PE;
      S_WAIT_PE:   if (pe_done) state_nxt = bank_full[cur_bank] ? S_BANK_WAIT : S_ADD;
      S_BANK_WAIT: if (!bank_full[cur_bank]) state_nxt = S_ADD;
      S_ADD:       if (tile_end) state_nxt = layer_end ? S_FLUSH : S_WAIT_PE;
      S_FLUSH:     if (bank_full == 2'b00) state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Set (tile end) and clear (drain) always hit different banks, so both apply.
  always_comb begin
    bank_full_nxt = bank_full;
    if (drain_fire) bank_full_nxt[drain_ptr] = 1'b0;
    if (tile_end)   bank_full_nxt[cur_bank]  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      cfg_ready      <= 1'b1;
      pe_hold        <= 1'b0;
      pe_psum_finish <= 1'b0;
      conv_finish    <= 1'b0;
      layer_done     <= 1'b0;
    end else begin
      state          <= state_nxt;
      cfg_ready      <= (state_nxt == S_IDLE);
      pe_hold        <= (state_nxt == S_BANK_WAIT) || (state_nxt == S_ADD) ||
                        (state_nxt == S_FLUSH) || (state_nxt == S_DONE);
      pe_psum_finish <= (state_nxt == S_ADD);
      conv_finish    <= layer_end;
      layer_done     <= (state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irrel_num    <= '0;
      tile_num_q   <= TILE_ONE;
      rf_entries_q <= RF_ONE;
      entry_cnt    <= '0;
      tile_cnt     <= '0;
      cur_bank     <= 1'b0;
    end else if (cfg_accept) begin
      irrel_num    <= irrel_coerced;
      tile_num_q   <= tile_coerced;
      rf_entries_q <= rf_coerced;
      entry_cnt    <= '0;
      tile_cnt     <= '0;
    end else if (add_step) begin
      if (tile_end) begin
        entry_cnt <= '0;
        tile_cnt  <= tile_inc;
        cur_bank  <= ~cur_bank;
      end else begin
        entry_cnt <= entry_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_full <= 2'b00;
      drain_ptr <= 1'b0;
    end else begin
      bank_full <= bank_full_nxt;
      if (drain_fire) drain_ptr <= ~drain_ptr;
    end
  end

`ifdef SU_CTRL_PERF_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_q <= '0;
    else if (cfg_accept)
      stall_q <= '0;
    else if ((state == S_BANK_WAIT) && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_su_adder_ctrl.sv
// Self-checking bench for su_adder_ctrl: vector table of layer configs, random
// layers against a bank-queue scoreboard, and hand sequences for stall/reset.
module tb_su_adder_ctrl;

  localparam int P = 2;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [4:0]   cfg_irrel_num = '0;
  logic [T-1:0] cfg_tile_num = '0;
  logic [P:0]   cfg_rf_entries = '0;
  logic         pe_done = 1'b0;
  logic         pe_hold;
  logic [4:0]   irrel_num;
  logic         pe_psum_finish;
  logic         su_add_finish = 1'b0;
  logic         conv_finish;
  logic         cur_bank;
  logic         drain_req;
  logic         drain_bank;
  logic         drain_ack = 1'b0;
  logic [T-1:0] tile_cnt;
  logic         layer_done;
  logic [15:0]  stall_cycles;

  su_adder_ctrl #(.PSUM_RF_ADDR_BITWIDTH(P), .TILE_BITWIDTH(T)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_irrel_num(cfg_irrel_num), .cfg_tile_num(cfg_tile_num),
    .cfg_rf_entries(cfg_rf_entries),
    .pe_done(pe_done), .pe_hold(pe_hold),
    .irrel_num(irrel_num), .pe_psum_finish(pe_psum_finish),
    .su_add_finish(su_add_finish), .conv_finish(conv_finish),
    .cur_bank(cur_bank), .drain_req(drain_req), .drain_bank(drain_bank),
    .drain_ack(drain_ack), .tile_cnt(tile_cnt), .layer_done(layer_done),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard: bank the next tile writes, drain pointer, FIFO of full banks.
  int model_bank = 0;
  int model_dptr = 0;
  int fullq[$];

  typedef struct {
    logic [4:0]   ir;
    logic [T-1:0] tn;
    logic [P:0]   rf;
    int           dmin;
    int           dmax;
    int           e_ir;
    int           e_tiles;
    int           e_ent;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    model_bank = 0;
    model_dptr = 0;
    fullq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".cfg_ready"}, cfg_ready, 1);
    chk({tag, ".pe_hold"}, pe_hold, 0);
    chk({tag, ".irrel_num"}, irrel_num, 0);
    chk({tag, ".pe_psum_finish"}, pe_psum_finish, 0);
    chk({tag, ".conv_finish"}, conv_finish, 0);
    chk({tag, ".cur_bank"}, cur_bank, 0);
    chk({tag, ".drain_req"}, drain_req, 0);
    chk({tag, ".drain_bank"}, drain_bank, 0);
    chk({tag, ".tile_cnt"}, tile_cnt, 0);
    chk({tag, ".layer_done"}, layer_done, 0);
    chk({tag, ".stall_cycles"}, stall_cycles, 0);
  endtask

  task automatic apply_cfg(input logic [4:0] ir, input logic [T-1:0] tn, input logic [P:0] rf);
    chk("cfg_ready_idle", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_irrel_num = ir;
    cfg_tile_num = tn;
    cfg_rf_entries = rf;
    tick();
    cfg_valid = 1'b0;
    chk("cfg_ready_busy", cfg_ready, 0);
    chk("tile_cnt_clear", tile_cnt, 0);
    chk("stall_clear", stall_cycles, 0);
  endtask

  task automatic wait_psf(input string tag);
    int c = 0;
    while (!pe_psum_finish && c < 50) begin
      tick();
      c++;
    end
    chk({tag, ".psf_seen"}, pe_psum_finish, 1);
  endtask

  task automatic wait_layer_done(input string tag);
    int c = 0;
    while (!layer_done && c < 50) begin
      tick();
      c++;
    end
    chk({tag, ".layer_done_seen"}, layer_done, 1);
  endtask

  // Environment: PE array, su_adder and drain engine with random timing.
  task automatic run_body(input int e_ir, input int e_tiles, input int e_ent,
                          input int dmin, input int dmax);
    int  tiles_started = 0;
    int  tiles_done = 0;
    int  adds = 0;
    int  conv_cnt = 0;
    int  done_cnt = 0;
    int  ack_wait = -1;
    int  cyc = 0;
    bit  psf_prev = 1'b0;
    bit  found;
    while (done_cnt == 0 && cyc < 4000) begin
      if (pe_done && pe_hold)
        pe_done = 1'b0;
      else if (!pe_done && !pe_hold && tiles_started < e_tiles && $urandom_range(0, 2) != 0) begin
        pe_done = 1'b1;
        tiles_started++;
      end
      su_add_finish = pe_psum_finish && ($urandom_range(0, 1) == 1);
      if (su_add_finish) adds++;
      drain_ack = 1'b0;
      if (drain_req && ack_wait < 0) ack_wait = $urandom_range(dmin, dmax);
      if (ack_wait == 0) begin
        ack_wait = -1;
        drain_ack = 1'b1;
        chk("drain_bank_order", drain_bank, (fullq.size() > 0) ? fullq[0] : -1);
        if (fullq.size() > 0) void'(fullq.pop_front());
        model_dptr ^= 1;
      end else if (ack_wait > 0) begin
        ack_wait--;
      end
      tick();
      cyc++;
      if (pe_psum_finish && !psf_prev) begin
        found = 1'b0;
        foreach (fullq[i]) if (fullq[i] == model_bank) found = 1'b1;
        chk("add_into_free_bank", found, 0);
        chk("irrel_num", irrel_num, e_ir);
        chk("cur_bank_at_add", cur_bank, model_bank);
      end
      if (!pe_psum_finish && psf_prev) begin
        tiles_done++;
        chk("entries_per_tile", adds, e_ent);
        adds = 0;
        fullq.push_back(model_bank);
        model_bank ^= 1;
        chk("cur_bank_toggle", cur_bank, model_bank);
        chk("tile_cnt", tile_cnt, tiles_done % 256);
        chk("conv_finish_at_tile_end", conv_finish, (tiles_done == e_tiles) ? 1 : 0);
      end
      if (conv_finish) conv_cnt++;
      chk("drain_req", drain_req, (fullq.size() != 0) ? 1 : 0);
      chk("drain_bank", drain_bank, model_dptr);
      if (layer_done) begin
        done_cnt++;
        chk("banks_empty_at_done", fullq.size(), 0);
      end
      psf_prev = pe_psum_finish;
    end
    pe_done = 1'b0;
    su_add_finish = 1'b0;
    drain_ack = 1'b0;
    chk("layer_done_seen", done_cnt, 1);
    chk("conv_finish_count", conv_cnt, 1);
    chk("tiles_done", tiles_done, e_tiles);
    tick();
    chk("layer_done_one_cycle", layer_done, 0);
    chk("cfg_ready_after_layer", cfg_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_exp;
    int ir, tn, rf, dm;

    tbl[0] = '{5'd7,  8'd1, 3'd4, 3, 3,  7,  1, 4};
    tbl[1] = '{5'd0,  8'd0, 3'd7, 0, 2,  1,  1, 4};
    tbl[2] = '{5'd5,  8'd3, 3'd2, 0, 0,  5,  3, 2};
    tbl[3] = '{5'd31, 8'd6, 3'd1, 2, 5,  31, 6, 1};
    tbl[4] = '{5'd3,  8'd4, 3'd3, 4, 9,  3,  4, 3};
    tbl[5] = '{5'd12, 8'd2, 3'd0, 1, 1,  12, 2, 1};
    tbl[6] = '{5'd1,  8'd5, 3'd4, 8, 14, 1,  5, 4};

    // Reset held: config ignored, outputs at reset values
    cfg_valid = 1'b1;
    cfg_irrel_num = 5'd9;
    cfg_tile_num = 8'd2;
    cfg_rf_entries = 3'd2;
    repeat (3) tick();
    check_reset_outputs("reset_hold");
    cfg_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_reset_outputs("reset_release");
    model_reset();

    // Ping-pong stall: 3 tiles of 2 entries, drain withheld until tile 2 waits
    apply_cfg(5'd4, 8'd3, 3'd2);
    for (int t = 0; t < 2; t++) begin
      pe_done = 1'b1;
      tick();
      pe_done = 1'b0;
      chk("pp_hold_after_pe_done", pe_hold, 1);
      wait_psf("pp_tile");
      for (int e = 0; e < 2; e++) begin
        su_add_finish = 1'b1;
        tick();
        su_add_finish = 1'b0;
      end
      chk("pp_psf_drop", pe_psum_finish, 0);
      chk("pp_cur_bank", cur_bank, (t == 0) ? 1 : 0);
      chk("pp_drain_req", drain_req, 1);
      chk("pp_drain_bank", drain_bank, 0);
      chk("pp_hold_released", pe_hold, 0);
    end
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    stall_exp = 1;
    chk("pp_bank_wait_hold", pe_hold, 1);
    chk("pp_bank_wait_no_add", pe_psum_finish, 0);
    repeat (4) begin
      tick();
      stall_exp++;
    end
    chk("pp_still_waiting", pe_psum_finish, 0);
    chk("pp_first_drain_bank", drain_bank, 0);
    drain_ack = 1'b1;
    tick();
    drain_ack = 1'b0;
    stall_exp++;
    chk("pp_no_add_at_k1", pe_psum_finish, 0);
    chk("pp_drain_ptr_moved", drain_bank, 1);
    chk("pp_bank1_still_full", drain_req, 1);
    tick();
    chk("pp_add_at_k2", pe_psum_finish, 1);
    chk("pp_add_bank0", cur_bank, 0);
`ifdef SU_CTRL_PERF_CNT_EN
    chk("pp_stall_cycles", stall_cycles, stall_exp);
`else
    chk("pp_stall_cycles", stall_cycles, 0);
`endif
    for (int e = 0; e < 2; e++) begin
      su_add_finish = 1'b1;
      tick();
      su_add_finish = 1'b0;
    end
    chk("pp_conv_finish", conv_finish, 1);
    chk("pp_tile_cnt", tile_cnt, 3);
    chk("pp_flush_hold", pe_hold, 1);
    tick();
    chk("pp_conv_one_cycle", conv_finish, 0);
    chk("pp_drain_bank1", drain_bank, 1);
    drain_ack = 1'b1;
    tick();
    drain_ack = 1'b0;
    chk("pp_drain_bank0_again", drain_bank, 0);
    chk("pp_last_bank_full", drain_req, 1);
    drain_ack = 1'b1;
    tick();
    drain_ack = 1'b0;
    wait_layer_done("pp");
`ifdef SU_CTRL_PERF_CNT_EN
    chk("pp_stall_held", stall_cycles, stall_exp);
`else
    chk("pp_stall_held", stall_cycles, 0);
`endif
    tick();
    model_bank = 1;
    model_dptr = 1;

    // Vector table of layer configs
    for (int i = 0; i < 7; i++) begin
      apply_cfg(tbl[i].ir, tbl[i].tn, tbl[i].rf);
      run_body(tbl[i].e_ir, tbl[i].e_tiles, tbl[i].e_ent, tbl[i].dmin, tbl[i].dmax);
    end

    // Spurious su_add_finish in WAIT_PE and drain_ack with no full bank
    apply_cfg(5'd2, 8'd1, 3'd2);
    repeat (3) begin
      su_add_finish = 1'b1;
      tick();
      su_add_finish = 1'b0;
    end
    repeat (2) begin
      drain_ack = 1'b1;
      tick();
      drain_ack = 1'b0;
    end
    chk("spur_tile_cnt", tile_cnt, 0);
    chk("spur_drain_req", drain_req, 0);
    chk("spur_drain_ptr", drain_bank, model_dptr);
    chk("spur_cur_bank", cur_bank, model_bank);
    chk("spur_no_add", pe_psum_finish, 0);
    run_body(2, 1, 2, 0, 3);

    // Random layers against the scoreboard
    for (int i = 0; i < 8; i++) begin
      ir = $urandom_range(0, 31);
      tn = $urandom_range(0, 6);
      rf = $urandom_range(0, 7);
      dm = $urandom_range(0, 10);
      apply_cfg(ir[4:0], tn[T-1:0], rf[P:0]);
      run_body((ir == 0) ? 1 : ir, (tn == 0) ? 1 : tn,
               (rf == 0) ? 1 : ((rf > 4) ? 4 : rf), 0, dm);
    end

    // Reset in the middle of ADD, then a clean layer
    apply_cfg(5'd7, 8'd1, 3'd4);
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    wait_psf("midreset");
    for (int e = 0; e < 2; e++) begin
      su_add_finish = 1'b1;
      tick();
      su_add_finish = 1'b0;
    end
    chk("midreset_in_add", pe_psum_finish, 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset_async");
    tick();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    tick();
    apply_cfg(5'd6, 8'd2, 3'd3);
    run_body(6, 2, 3, 0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
